sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO: the next generation of our 8-entry FIFO, generalised in data width and depth.
//  Adds registered read data with a valid strobe, almost-full/almost-empty thresholds, an occupancy count,
//  sticky overflow/underflow error flags and a synchronous flush. Buffers data between a producer and a
//  consumer in the same clk_i domain; both sides use a level-sensitive enable handshake.
// PARAMETERS
//  DATA_W     8   data word width in bits (>=1)
//  DEPTH      8   number of entries; power of 2, >=2
//  AF_THRESH  6   almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
//  AW = $clog2(DEPTH) is a localparam, not a parameter. Elaboration-time error if DEPTH is not a power of 2.
// PORTS
//  clk_i           in   1         clock, rising edge
//  reset_i         in   1         asynchronous reset, active-low
//  clr_i           in   1         synchronous flush: empties the FIFO and clears the error flags
//  wr_en_i         in   1         write request
//  wr_data_i       in   DATA_W    write data
//  rd_en_i         in   1         read request
//  rd_data_o       out  DATA_W    read data, registered
//  rd_valid_o      out  1         one-cycle pulse: rd_data_o holds the word from the read accepted last cycle
//  full_o          out  1         count == DEPTH
//  empty_o         out  1         count == 0
//  almost_full_o   out  1         count >= AF_THRESH
//  almost_empty_o  out  1         count <= AE_THRESH
//  count_o         out  AW+1      current occupancy, 0..DEPTH
//  overflow_o      out  1         sticky: a write was rejected
//  underflow_o     out  1         sticky: a read was rejected
// BEHAVIOUR
//  Reset (reset_i low, asynchronous): wr_ptr, rd_ptr and count are 0; rd_data_o is 0; rd_valid_o is 0.
//   full_o, almost_full_o, overflow_o and underflow_o are 0. empty_o is 1.
//   almost_empty_o is 1 (because count 0 <= AE_THRESH). Memory contents are not reset.
//  rd_acc = rd_en_i & ~empty_o. wr_acc = wr_en_i & (~full_o | rd_en_i).
//   When the FIFO is full, a simultaneous read frees a slot, so the write is accepted.
//   When the FIFO is empty, there is no fall-through: a read is rejected even if a write arrives in the same cycle.
//  Write: on wr_acc, mem[wr_ptr] <= wr_data_i and wr_ptr <= wr_ptr+1.
//   The pointer is AW bits wide and wraps naturally from DEPTH-1 to 0.
//  Read: on rd_acc, rd_data_o <= mem[rd_ptr], rd_ptr <= rd_ptr+1 (wraps), and rd_valid_o <= 1 for one cycle.
//   Read latency is 1 cycle. rd_data_o holds its value when no read is accepted.
//  Count update:
//   wr_acc only:  count+1
//   rd_acc only:  count-1
//   both:         count unchanged
//   neither:      count unchanged
//   count never leaves the range 0..DEPTH.
//  All status outputs decode from the registered count and registered pointers only.
//   There is no combinational path from any input to any output.
//  Errors:
//   overflow_o <= 1 when wr_en_i & ~wr_acc.
//   underflow_o <= 1 when rd_en_i & ~rd_acc.
//   Both flags hold until clr_i or reset_i.
//   A rejected access changes no pointer, no count and no memory.
//  clr_i has priority over wr_en_i and rd_en_i in the same cycle. It sets pointers and count to 0,
//   rd_valid_o to 0 and both error flags to 0. rd_data_o keeps its value.
//  Reset asserted mid-operation aborts any in-flight access. After release, the FIFO is empty
//   and the previous contents are unreachable.
// STRUCTURE
//  Shared package fifo_pkg: the function that checks DEPTH is a power of 2, and a count-width helper
//   (clog2(DEPTH)+1).
//  Sub-module fifo_mem_2p(DATA_W, DEPTH): simple dual-port register array with one write port and one
//   synchronous read port, and no reset. The top level keeps the pointers, the count, the flags and the
//   error logic.
// TESTING (DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
//  1. Reset, then write 0x10..0x17 over 8 cycles.
//     -> full_o=1 and count_o=8.
//     -> almost_full_o rises on the edge where count reaches 6.
//     -> empty_o=0.
//  2. From full, read 8 times.
//     -> rd_valid_o pulses with rd_data_o = 0x10..0x17, in order, each 1 cycle after its read.
//     -> empty_o=1 after the 8th read.
//     -> almost_empty_o=1 once count <= 2.
//  3. At full, write 0xAA with rd_en_i=0.
//     -> overflow_o=1, count stays 8, and the data read back later contains no 0xAA.
//     Then, at empty, read.
//     -> underflow_o=1 and rd_valid_o=0.
//  4. At full, write 0x55 and read in the same cycle.
//     -> both are accepted, count stays 8, overflow_o stays 0, and 0x55 is the last word drained.
//  5. Wrap-around: push 5, pop 5, then push 6 (0x20..0x25) and pop 6.
//     -> data comes out in order across the pointer wrap and count_o tracks exactly.
//  6. With count=4 and overflow_o=1, assert clr_i together with wr_en_i.
//     -> the next cycle shows count_o=0, empty_o=1, overflow_o=0, and no write took place.
//     Then, with count=3, assert reset_i mid-stream.
//     -> all outputs show their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO family: depth legality and count width.
package fifo_pkg;

    function automatic bit is_pow2(input int unsigned value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port register array: one write port, one synchronous read port, no reset.
module fifo_mem_2p #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value between accepted reads.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, thresholds, occupancy count,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AW:0]       count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned CW = count_w(DEPTH);
    localparam logic [AW:0] DepthC = CW'(DEPTH);
    localparam logic [AW:0] AfC    = CW'(AF_THRESH);
    localparam logic [AW:0] AeC    = CW'(AE_THRESH);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW-1:0]     r_wr_ptr, w_wr_ptr_d;
    logic [AW-1:0]     r_rd_ptr, w_rd_ptr_d;
    logic [AW:0]       r_count, w_count_d;
    logic              r_rd_valid, w_rd_valid_d;
    logic              r_overflow, w_overflow_d;
    logic              r_underflow, w_underflow_d;
    logic              r_rd_primed;
    logic              w_wr_acc, w_rd_acc;
    logic              w_mem_wr, w_mem_rd;
    logic [DATA_W-1:0] w_mem_rdata;

    // Status decodes from registered state only.
    assign full_o         = (r_count == DepthC);
    assign empty_o        = (r_count == '0);
    assign almost_full_o  = (r_count >= AfC);
    assign almost_empty_o = (r_count <= AeC);
    assign count_o        = r_count;
    assign rd_valid_o     = r_rd_valid;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

    // A read at full frees a slot, so the write may proceed; no fall-through when empty.
    assign w_rd_acc = rd_en_i & ~empty_o;
    assign w_wr_acc = wr_en_i & (~full_o | rd_en_i);
    assign w_mem_wr = w_wr_acc & ~clr_i;
    assign w_mem_rd = w_rd_acc & ~clr_i;

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr;
        w_rd_ptr_d    = r_rd_ptr;
        w_count_d     = r_count;
        w_rd_valid_d  = 1'b0;
        w_overflow_d  = r_overflow;
        w_underflow_d = r_underflow;
        if (clr_i) begin
            w_wr_ptr_d    = '0;
            w_rd_ptr_d    = '0;
            w_count_d     = '0;
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_d = r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                w_rd_ptr_d   = r_rd_ptr + AW'(1);
                w_rd_valid_d = 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_d = r_count + CW'(1);
                2'b01:   w_count_d = r_count - CW'(1);
                default: w_count_d = r_count;
            endcase
            if (wr_en_i & ~w_wr_acc) begin
                w_overflow_d = 1'b1;
            end
            if (rd_en_i & ~w_rd_acc) begin
                w_underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_d;
            r_rd_ptr    <= w_rd_ptr_d;
            r_count     <= w_count_d;
            r_rd_valid  <= w_rd_valid_d;
            r_overflow  <= w_overflow_d;
            r_underflow <= w_underflow_d;
        end
    end

    // The memory read register has no reset; mask it to zero until the first accepted read.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_primed <= 1'b0;
        end else if (w_mem_rd) begin
            r_rd_primed <= 1'b1;
        end
    end

    assign rd_data_o = r_rd_primed ? w_mem_rdata : '0;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (w_mem_wr),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_mem_rd),
        .rd_addr_i (r_rd_ptr),
        .rd_data_o (w_mem_rdata)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: reads queue hand-computed words, a monitor checks them.
module tb_sync_fifo_param;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       clr_i, wr_en_i, rd_en_i;
    logic [7:0] wr_data_i;
    logic [7:0] rd_data_o;
    logic       rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [3:0] count_o;
    logic       overflow_o, underflow_o;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    sync_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clr_i          (clr_i),
        .wr_en_i        (wr_en_i),
        .wr_data_i      (wr_data_i),
        .rd_en_i        (rd_en_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk_i) begin
        if (reset_i === 1'b1 && rd_valid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got %0h want none", rd_data_o);
            end else begin
                logic [7:0] want;
                want = exp_q.pop_front();
                if (rd_data_o !== want) begin
                    bad++;
                    $display("FAIL rd_data: got %0h want %0h at %0t", rd_data_o, want, $time);
                end
            end
        end
    end

    task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_en_i   = w;
        wr_data_i = d;
        rd_en_i   = r;
        clr_i     = c;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        op(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [7:0] want);
        exp_q.push_back(want);
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rd_valid_pulse", int'(rd_valid_o), 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(count_o), 0);
        chk({tag, "_empty"}, int'(empty_o), 1);
        chk({tag, "_full"}, int'(full_o), 0);
        chk({tag, "_afull"}, int'(almost_full_o), 0);
        chk({tag, "_aempty"}, int'(almost_empty_o), 1);
        chk({tag, "_valid"}, int'(rd_valid_o), 0);
        chk({tag, "_rdata"}, int'(rd_data_o), 0);
        chk({tag, "_ovf"}, int'(overflow_o), 0);
        chk({tag, "_udf"}, int'(underflow_o), 0);
    endtask

    initial begin
        reset_i = 1'b1; clr_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; wr_data_i = 8'h00;
        #2 reset_i = 1'b0;
        #2 chk_reset_state("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;

        // 1: fill 0x10..0x17
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h10 + i));
            chk("fill_count", int'(count_o), i + 1);
            chk("fill_afull", int'(almost_full_o), (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill_full", int'(full_o), 1);
        chk("fill_empty", int'(empty_o), 0);

        // 2: drain in order
        for (int i = 0; i < 8; i++) begin
            pop(8'(8'h10 + i));
            chk("drain_count", int'(count_o), 7 - i);
            chk("drain_aempty", int'(almost_empty_o), (7 - i <= 2) ? 1 : 0);
        end
        chk("drain_empty", int'(empty_o), 1);

        // 3: overflow at full, then underflow at empty
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        op(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_count", int'(count_o), 8);
        for (int i = 0; i < 8; i++) pop(8'(8'h30 + i));
        op(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_flag", int'(underflow_o), 1);
        chk("udf_valid", int'(rd_valid_o), 0);
        chk("udf_count", int'(count_o), 0);

        // 4: simultaneous write+read at full
        op(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow_o), 0);
        chk("clr_udf", int'(underflow_o), 0);
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        exp_q.push_back(8'h40);
        op(1'b1, 8'h55, 1'b1, 1'b0);
        chk("wr_rd_full_count", int'(count_o), 8);
        chk("wr_rd_full_ovf", int'(overflow_o), 0);
        chk("wr_rd_full_full", int'(full_o), 1);
        for (int i = 1; i < 8; i++) pop(8'(8'h40 + i));
        pop(8'h55);
        chk("wr_rd_empty", int'(empty_o), 1);

        // 5: wrap-around
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h50 + i));
            chk("wrap_push5_count", int'(count_o), i + 1);
        end
        for (int i = 0; i < 5; i++) begin
            pop(8'(8'h50 + i));
            chk("wrap_pop5_count", int'(count_o), 4 - i);
        end
        for (int i = 0; i < 6; i++) begin
            push(8'(8'h20 + i));
            chk("wrap_push6_count", int'(count_o), i + 1);
        end
        for (int i = 0; i < 6; i++) begin
            pop(8'(8'h20 + i));
            chk("wrap_pop6_count", int'(count_o), 5 - i);
        end

        // 6: clear beats write, then async reset mid-stream
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        op(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pop(8'(8'h60 + i));
        chk("pre_clr_count", int'(count_o), 4);
        chk("pre_clr_ovf", int'(overflow_o), 1);
        op(1'b1, 8'h99, 1'b0, 1'b1);
        chk("clr_count", int'(count_o), 0);
        chk("clr_empty", int'(empty_o), 1);
        chk("clr_ovf2", int'(overflow_o), 0);
        chk("clr_rdata_kept", int'(rd_data_o), 8'h63);
        push(8'h71);
        chk("post_clr_count", int'(count_o), 1);
        pop(8'h71);
        for (int i = 0; i < 3; i++) push(8'(8'h72 + i));
        chk("pre_reset_count", int'(count_o), 3);
        #2 reset_i = 1'b0;
        #1 chk_reset_state("midreset");
        @(negedge clk_i);
        reset_i = 1'b1;
        push(8'h80);
        chk("after_reset_count", int'(count_o), 1);
        pop(8'h80);
        op(1'b0, 8'h00, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
